// File: rtl/router_egress_arbiter.sv
// router_egress_arbiter: packet-granular round-robin reader for three output
// FIFOs. It merges the granted FIFO onto one valid/ready byte stream tagged
// with SOP/EOP/port, and a stall watchdog flushes and aborts stuck packets.
module router_egress_arbiter #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] fifo_empty,
  input  logic [7:0] fifo_data0,
  input  logic [7:0] fifo_data1,
  input  logic [7:0] fifo_data2,
  output logic [2:0] read_enb,
  output logic [2:0] soft_reset,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_port,
  output logic       pkt_abort,
  output logic       busy
);

  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned REM_W = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HDR    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } buf_entry_t;

  logic [1:0]       state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  buf_entry_t       ent0_q, ent0_d, ent1_q, ent1_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic             inf_q, inf_d;
  logic             inf_sop_q, inf_sop_d;
  logic             inf_eop_q, inf_eop_d;
  logic [1:0]       inf_port_q, inf_port_d;
  logic [2:0]       soft_reset_q, soft_reset_d;
  logic             pkt_abort_q, pkt_abort_d;
  logic             busy_q, busy_d;

  logic [1:0]       cand0_c, cand1_c, cand2_c, pick_c;
  logic [7:0]       sel_data_c;
  logic [REM_W-1:0] hdr_rem_c, eff_rem_c;
  logic [2:0]       lvl_c;
  logic             pop_c, room_c, gnt_empty_c;
  logic             rd_c, rd_sop_c, rd_eop_c, stall_c;
  buf_entry_t       new_ent_c;

  assign cand0_c = rr_ptr_q;
  assign cand1_c = (rr_ptr_q == 2'd2) ? 2'd0 : rr_ptr_q + 2'd1;
  assign cand2_c = (rr_ptr_q == 2'd0) ? 2'd2 : rr_ptr_q - 2'd1;

  assign pop_c       = v0_q & out_ready;
  assign gnt_empty_c = fifo_empty[gnt_q];
  assign lvl_c       = 3'(v0_q) + 3'(v1_q) + 3'(inf_q) - 3'(pop_c);
  assign room_c      = (lvl_c < 3'd2);

  // Round-robin pick of the first non-empty FIFO starting at rr_ptr.
  always_comb begin
    pick_c = cand0_c;
    if (fifo_empty[cand0_c]) begin
      pick_c = cand1_c;
      if (fifo_empty[cand1_c]) begin
        pick_c = cand2_c;
      end
    end
  end

  // Select the data returning from last cycle's read.
  always_comb begin
    case (inf_port_q)
      2'd0:    sel_data_c = fifo_data0;
      2'd1:    sel_data_c = fifo_data1;
      2'd2:    sel_data_c = fifo_data2;
      default: sel_data_c = 8'd0;
    endcase
  end

  // A header arriving this cycle supplies the remaining count immediately so
  // streaming can continue back-to-back behind it.
  assign hdr_rem_c = REM_W'(sel_data_c[7:2]) + REM_W'(1);
  assign eff_rem_c = (inf_q && inf_sop_q) ? hdr_rem_c : rem_q;

  // Next-state, read issue and watchdog.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    rem_d        = rem_q;
    wd_d         = wd_q;
    rd_c         = 1'b0;
    rd_sop_c     = 1'b0;
    rd_eop_c     = 1'b0;
    stall_c      = 1'b0;
    soft_reset_d = 3'b000;
    pkt_abort_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (fifo_empty != 3'b111) begin
          gnt_d    = pick_c;
          rr_ptr_d = (pick_c == 2'd2) ? 2'd0 : pick_c + 2'd1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        stall_c = gnt_empty_c;
        if (!gnt_empty_c && room_c) begin
          rd_c     = 1'b1;
          rd_sop_c = 1'b1;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        rem_d   = eff_rem_c;
        stall_c = gnt_empty_c && (eff_rem_c != '0);
        if (!gnt_empty_c && room_c && (eff_rem_c != '0)) begin
          rd_c  = 1'b1;
          rem_d = eff_rem_c - REM_W'(1);
          if (eff_rem_c == REM_W'(1)) begin
            rd_eop_c = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (stall_c) begin
      if (wd_q == WD_W'(TIMEOUT - 1)) begin
        soft_reset_d = 3'b001 << gnt_q;
        pkt_abort_d  = 1'b1;
        wd_d         = '0;
        rem_d        = '0;
        state_d      = ST_IDLE;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end else if (state_q != ST_IDLE) begin
      wd_d = '0;
    end
  end

  assign read_enb = rd_c ? (3'b001 << gnt_q) : 3'b000;

  // Two-entry output buffer; empty entries are kept all-zero.
  always_comb begin
    new_ent_c  = '{data: sel_data_c, sop: inf_sop_q, eop: inf_eop_q, port: inf_port_q};
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    inf_d      = rd_c;
    inf_sop_d  = rd_sop_c;
    inf_eop_d  = rd_eop_c;
    inf_port_d = gnt_q;
    busy_d     = (state_d != ST_IDLE);

    if (pop_c) begin
      if (v1_q) begin
        ent0_d = ent1_q;
        v0_d   = 1'b1;
        if (inf_q) begin
          ent1_d = new_ent_c;
          v1_d   = 1'b1;
        end else begin
          ent1_d = '0;
          v1_d   = 1'b0;
        end
      end else if (inf_q) begin
        ent0_d = new_ent_c;
        v0_d   = 1'b1;
      end else begin
        ent0_d = '0;
        v0_d   = 1'b0;
      end
    end else if (inf_q) begin
      if (!v0_q) begin
        ent0_d = new_ent_c;
        v0_d   = 1'b1;
      end else begin
        ent1_d = new_ent_c;
        v1_d   = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= 2'd0;
      gnt_q        <= 2'd0;
      rem_q        <= '0;
      wd_q         <= '0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      inf_q        <= 1'b0;
      inf_sop_q    <= 1'b0;
      inf_eop_q    <= 1'b0;
      inf_port_q   <= 2'd0;
      soft_reset_q <= 3'b000;
      pkt_abort_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      rem_q        <= rem_d;
      wd_q         <= wd_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      inf_q        <= inf_d;
      inf_sop_q    <= inf_sop_d;
      inf_eop_q    <= inf_eop_d;
      inf_port_q   <= inf_port_d;
      soft_reset_q <= soft_reset_d;
      pkt_abort_q  <= pkt_abort_d;
      busy_q       <= busy_d;
    end
  end

  assign out_data   = ent0_q.data;
  assign out_sop    = ent0_q.sop;
  assign out_eop    = ent0_q.eop;
  assign out_port   = ent0_q.port;
  assign out_valid  = v0_q;
  assign soft_reset = soft_reset_q;
  assign pkt_abort  = pkt_abort_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Testbench for router_egress_arbiter: behavioural FIFO models, an egress
// monitor, a table of directed packet scenarios, and stall/reset sequences.
module tb_router_egress_arbiter;

  logic       clock;
  logic       resetn;
  logic       out_ready;
  logic       tb_flush;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] soft_reset;
  logic [7:0] fd [3];
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop, pkt_abort, busy;
  logic [1:0] out_port;

  router_egress_arbiter #(.TIMEOUT(30)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .fifo_empty (fifo_empty),
    .fifo_data0 (fd[0]),
    .fifo_data1 (fd[1]),
    .fifo_data2 (fd[2]),
    .read_enb   (read_enb),
    .soft_reset (soft_reset),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_port   (out_port),
    .pkt_abort  (pkt_abort),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO models: data_out registered on the read edge.
  logic [7:0] mem [3][2048];
  int wr_ptr [3];
  int rd_ptr [3];
  int cyc;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (tb_flush || soft_reset[i]) begin
        rd_ptr[i] <= wr_ptr[i];
      end else if (read_enb[i] && (rd_ptr[i] != wr_ptr[i])) begin
        fd[i]     <= mem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  assign fifo_empty = {rd_ptr[2] == wr_ptr[2], rd_ptr[1] == wr_ptr[1], rd_ptr[0] == wr_ptr[0]};

  // Egress monitor and protocol invariants, sampled on the falling edge.
  logic [11:0] cap [$];
  int   cap_cyc [$];
  int   rd_cnt, pop_cnt, viol, last_rd_cyc, n_abort, abort_cyc, n_srst;
  logic busy_after_rd, rd_prev;
  logic [2:0] srst_val;

  always @(negedge clock) begin
    if (!resetn) begin
      rd_cnt  = 0;
      pop_cnt = 0;
      rd_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        cap.push_back({out_data, out_sop, out_eop, out_port});
        cap_cyc.push_back(cyc);
      end
      if (read_enb != 3'b000) begin
        if (!$onehot(read_enb)) viol++;
        if ((rd_cnt - pop_cnt - int'(out_valid && out_ready)) >= 2) viol++;
        last_rd_cyc = cyc;
      end
      if ((soft_reset & read_enb) != 3'b000) viol++;
      if (rd_prev) busy_after_rd = busy;
      if (pkt_abort) begin
        n_abort++;
        abort_cyc = cyc;
      end
      if (soft_reset != 3'b000) begin
        n_srst++;
        srst_val = soft_reset;
      end
      rd_cnt  += int'(read_enb != 3'b000);
      pop_cnt += int'(out_valid && out_ready);
      rd_prev = (read_enb != 3'b000);
    end
  end

  int total, bad;

  task automatic check(input string name, input longint got, input longint expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int port, input int len, input int seed, input int idx);
    logic [7:0] b, par, res;
    par = 8'd0;
    res = 8'd0;
    for (int j = 0; j <= len; j++) begin
      b = (j == 0) ? {6'(len), 2'(port)} : 8'(seed * 37 + j * 13 + port * 5);
      if (j == idx) res = b;
      par ^= b;
    end
    if (idx == len + 1) res = par;
    return res;
  endfunction

  task automatic push_pkt(input int port, input int len, input int seed, input int nwrite);
    for (int j = 0; j < nwrite; j++) mem[port][wr_ptr[port] + j] = pkt_byte(port, len, seed, j);
    wr_ptr[port] = wr_ptr[port] + nwrite;
  endtask

  typedef struct packed {
    logic [2:0] mask;
    logic [5:0] len;
    logic       toggle;
    logic [1:0] npkt;
    logic [5:0] ord;
    logic [9:0] nbytes;
  } vec_t;

  vec_t vecs [8];
  logic [11:0] expq [$];

  task automatic build_exp(input int port, input int len, input int seed, input int nbytes);
    for (int idx = 0; idx < nbytes; idx++)
      expq.push_back({pkt_byte(port, len, seed, idx), idx == 0, idx == len + 1, 2'(port)});
  endtask

  // Load the FIFOs named in a vector, wait for the egress stream, compare.
  task automatic run_vec(input int id, input vec_t v, input int seed);
    int start, load_cyc, n, mism, p, len;
    bit done;
    len = int'(v.len);
    start = cap.size();
    expq.delete();
    for (int k = 0; k < int'(v.npkt); k++) begin
      p = int'(v.ord[2*k +: 2]);
      build_exp(p, len, seed, len + 2);
    end
    for (int i = 0; i < 3; i++) if (v.mask[i]) push_pkt(i, len, seed, len + 2);
    load_cyc = cyc;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(posedge clock); #1;
      if (v.toggle) out_ready = ~out_ready;
      if ((cap.size() - start) >= int'(v.nbytes) && !busy && !out_valid) done = 1'b1;
    end
    out_ready = 1'b1;
    repeat (4) begin @(posedge clock); #1; end
    check($sformatf("v%0d completed", id), done, 1);
    n = cap.size() - start;
    check($sformatf("v%0d byte count", id), n, v.nbytes);
    mism = 0;
    for (int i = 0; i < n && i < expq.size(); i++) begin
      if (cap[start + i] !== expq[i]) begin
        if (mism == 0)
          $display("FAIL v%0d byte %0d: got %03h expected %03h", id, i, cap[start + i], expq[i]);
        mism++;
      end
    end
    check($sformatf("v%0d stream mismatches", id), mism, 0);
    check($sformatf("v%0d busy after final read", id), busy_after_rd, 0);
    if (!v.toggle && n > 0) begin
      check($sformatf("v%0d first byte latency", id), cap_cyc[start] - load_cyc, 3);
      check($sformatf("v%0d egress span", id), cap_cyc[start + n - 1] - cap_cyc[start],
            int'(v.nbytes) - 1 + int'(v.npkt) - 1);
    end
  endtask

  initial begin
    int start, a0, s0, n, mism, eops;
    bit done;
    // mask, len, toggle, npkt, order (first in [1:0]), expected byte count
    vecs[0] = '{mask: 3'b111, len: 6'd2,  toggle: 1'b0, npkt: 2'd3, ord: 6'b10_01_00, nbytes: 10'd12};
    vecs[1] = '{mask: 3'b101, len: 6'd2,  toggle: 1'b0, npkt: 2'd2, ord: 6'b00_10_00, nbytes: 10'd8};
    vecs[2] = '{mask: 3'b010, len: 6'd3,  toggle: 1'b0, npkt: 2'd1, ord: 6'b00_00_01, nbytes: 10'd5};
    vecs[3] = '{mask: 3'b001, len: 6'd0,  toggle: 1'b0, npkt: 2'd1, ord: 6'b00_00_00, nbytes: 10'd2};
    vecs[4] = '{mask: 3'b011, len: 6'd1,  toggle: 1'b0, npkt: 2'd2, ord: 6'b00_00_01, nbytes: 10'd6};
    vecs[5] = '{mask: 3'b100, len: 6'd5,  toggle: 1'b1, npkt: 2'd1, ord: 6'b00_00_10, nbytes: 10'd7};
    vecs[6] = '{mask: 3'b111, len: 6'd63, toggle: 1'b0, npkt: 2'd3, ord: 6'b10_01_00, nbytes: 10'd195};
    vecs[7] = '{mask: 3'b110, len: 6'd2,  toggle: 1'b0, npkt: 2'd2, ord: 6'b00_10_01, nbytes: 10'd8};

    resetn    = 1'b0;
    out_ready = 1'b1;
    tb_flush  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset outputs", {read_enb, soft_reset, out_data, out_valid, out_sop, out_eop,
                            out_port, pkt_abort, busy}, 0);
    resetn = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < 7; v++) run_vec(v, vecs[v], v + 1);

    // Stall: header says L=4 but only two payload bytes ever arrive.
    start = cap.size();
    a0 = n_abort;
    s0 = n_srst;
    expq.delete();
    build_exp(2, 4, 20, 3);
    push_pkt(2, 4, 20, 3);
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(posedge clock); #1;
      if (n_abort != a0) done = 1'b1;
    end
    repeat (5) begin @(posedge clock); #1; end
    check("stall abort seen", done, 1);
    n = cap.size() - start;
    check("stall byte count", n, 3);
    mism = 0;
    eops = 0;
    for (int i = 0; i < n; i++) begin
      if (i < expq.size() && cap[start + i] !== expq[i]) mism++;
      if (cap[start + i][2]) eops++;
    end
    check("stall stream mismatches", mism, 0);
    check("stall eop count", eops, 0);
    check("stall abort pulses", n_abort - a0, 1);
    check("stall soft_reset pulses", n_srst - s0, 1);
    check("stall soft_reset value", srst_val, 3'b100);
    check("stall timeout cycles", abort_cyc - last_rd_cyc, 31);
    check("stall busy after abort", busy, 0);

    // Reset in the middle of a long packet, then serve fresh traffic.
    start = cap.size();
    push_pkt(1, 20, 30, 22);
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(posedge clock); #1;
      if ((cap.size() - start) >= 5) done = 1'b1;
    end
    check("mid-packet streaming reached", done, 1);
    resetn   = 1'b0;
    tb_flush = 1'b1;
    @(posedge clock); #1;
    resetn   = 1'b1;
    tb_flush = 1'b0;
    check("outputs after mid-packet reset", {read_enb, soft_reset, out_data, out_valid, out_sop,
                                             out_eop, out_port, pkt_abort, busy}, 0);
    @(posedge clock); #1;
    run_vec(7, vecs[7], 40);

    check("protocol invariant violations", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
